// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way combinational picker: round-robin or fixed priority for master 1.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       prio_m1,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = M0;
    unique case (req)
      2'b10:   gnt_idx = M1;
      2'b11:   gnt_idx = prio_m1 ? M1 : ~last_gnt;
      default: gnt_idx = M0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-RAM port between the CPU path (m0) and the loader (m1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 14,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prio_m1,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_err
    $error("mem_port_arbiter: RD_LAT must be 1..4");
  end

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  state_t     state_nx;
  logic       gnt_q;
  logic       we_q;
  logic       last_gnt;
  logic [2:0] cnt;
  logic       gnt_valid;
  logic       gnt_idx;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .prio_m1   (prio_m1),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ram_addr/ram_wdata double as the latched request; they hold between accesses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q     <= M0;
      we_q      <= 1'b0;
      last_gnt  <= M1;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (state == IDLE && gnt_valid) begin
        gnt_q     <= gnt_idx;
        last_gnt  <= gnt_idx;
        we_q      <= gnt_idx ? m1_we    : m0_we;
        ram_addr  <= gnt_idx ? m1_addr  : m0_addr;
        ram_wdata <= gnt_idx ? m1_wdata : m0_wdata;
      end
      if (state == ISSUE && !we_q) cnt <= LAT;
      if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (gnt_q == M1) m1_rdata <= ram_rdata;
          else             m0_rdata <= ram_rdata;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt_valid) state_nx = ISSUE;
      ISSUE: state_nx = we_q ? ACK : WAIT;
      WAIT:  if (cnt == 3'd1) state_nx = ACK;
      ACK:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram_en = (state == ISSUE);
    ram_we = (state == ISSUE) && we_q;
    m0_ack = (state == ACK) && (gnt_q == M0);
    m1_ack = (state == ACK) && (gnt_q == M1);
    busy   = (state != IDLE);
  end

endmodule
